// File: rtl/calc_core_param.sv
// Stepped calculator core: load-A / load-B / execute / show sequencer with
// a registered ALU result, status flags and a multiplexed hex-display scanner.
module calc_core_param #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DIGITS   = WIDTH / 4,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              next,
   input  logic [2:0]        MS,
   input  logic [WIDTH-1:0]  Din,
   input  logic              level,
   output logic [WIDTH-1:0]  Alu_out,
   output logic              Done_out,
   output logic [3:0]        flags,
   output logic [2:0]        state_out,
   output logic [3:0]        digit,
   output logic [DIGITS-1:0] LEDsel
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DW = 4 * DIGITS;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_EXEC   = 3'd3,
      S_SHOW   = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d;
   logic [2:0]       op_q, op_d;
   logic [3:0]       flags_q, flags_d;
   logic             done_q, done_d;
   logic             next_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic             step_c;
   logic [WIDTH:0]   sum_c, dif_c;
   logic [WIDTH-1:0] res_c, disp_c;
   logic [DW-1:0]    disp_ext_c;
   logic             carry_c, ovf_c;

   assign step_c = next & ~next_q;
   assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
   assign dif_c  = {1'b0, a_q} - {1'b0, b_q};

   // ALU on the held operands; only sampled into alu_q/flags_q in EXEC
   always_comb begin
      res_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      case (op_q)
         3'b000: begin
            res_c   = sum_c[WIDTH-1:0];
            carry_c = sum_c[WIDTH];
            ovf_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         3'b001: begin
            res_c   = dif_c[WIDTH-1:0];
            carry_c = dif_c[WIDTH];
            ovf_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         3'b010: res_c = a_q & b_q;
         3'b011: res_c = a_q | b_q;
         3'b100: res_c = a_q ^ b_q;
         3'b101: begin
            res_c   = {a_q[WIDTH-2:0], 1'b0};
            carry_c = a_q[WIDTH-1];
         end
         3'b110: begin
            res_c   = {1'b0, a_q[WIDTH-1:1]};
            carry_c = a_q[0];
         end
         default: res_c = a_q;
      endcase
   end

   // Step sequencer and operand/result capture
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      alu_d   = alu_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE:   if (step_c) state_d = S_LOAD_A;
         S_LOAD_A: if (step_c) begin
            state_d = S_LOAD_B;
            a_d     = Din;
         end
         S_LOAD_B: if (step_c) begin
            state_d = S_EXEC;
            b_d     = Din;
            op_d    = MS;
         end
         S_EXEC: begin
            state_d = S_SHOW;
            alu_d   = res_c;
            flags_d = {carry_c, ovf_c, res_c[WIDTH-1], (res_c == '0)};
         end
         S_SHOW:   if (step_c) state_d = S_LOAD_A;
         default:  state_d = S_IDLE;
      endcase
      done_d = (state_d == S_SHOW);
   end

   // Digit-slot timer and digit index
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      case (state_q)
         S_LOAD_A, S_LOAD_B: disp_c = Din;
         S_EXEC, S_SHOW:     disp_c = level ? a_q : alu_q;
         default:            disp_c = '0;
      endcase
      disp_ext_c = DW'(disp_c);
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         alu_q   <= '0;
         flags_q <= '0;
         done_q  <= 1'b0;
         next_q  <= 1'b1;  // a button held through reset must not count as a step
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         alu_q   <= alu_d;
         flags_q <= flags_d;
         done_q  <= done_d;
         next_q  <= next;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   assign Alu_out   = alu_q;
   assign flags     = flags_q;
   assign Done_out  = done_q;
   assign state_out = state_q;
   assign digit     = 4'(disp_ext_c >> {idx_q, 2'b00});
   assign LEDsel    = ~(DIGITS'(1) << idx_q);

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
Parametrised successor to the fixed 16-bit calculator top level. It combines the step FSM, the operand registers, the ALU and the multiplexed hex-display scanner in one synchronous block. The user steps through a load-A / load-B / execute / show sequence with a `next` pushbutton. Operand width, display digit count and scan rate are generics, and the block adds status flags and a registered result.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
DIGITS, WIDTH/4, number of hex display digits scanned
SCAN_DIV, 50000, clk cycles per display digit slot; must be at least 2

Ports:
clk  in  1  system clock, all state on rising edge
clear  in  1  asynchronous active-low reset
next  in  1  step request; level signal, internally edge-detected
MS  in  3  operation select, captured at the LOAD_B step
Din  in  WIDTH  operand input from switches
level  in  1  display source select in EXEC/SHOW: 0 = result, 1 = operand A
Alu_out  out  WIDTH  registered result
Done_out  out  1  high while in SHOW
flags  out  4  {carry, overflow, negative, zero} of last result, registered
state_out  out  3  current FSM state encoding
digit  out  4  hex nibble for the currently selected digit
LEDsel  out  DIGITS  one-hot, active-low digit enable

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE.
  - Alu_out=0, flags=0, Done_out=0.
  - Operand registers A=0, B=0, op=0.
  - Scan counter=0, digit index=0, so LEDsel has bit0 low and all other bits high.
  - next_q=1. This blocks a false edge if the button is held through reset.
- Step pulse: step = next & ~next_q, with next_q registered each cycle. Exactly one step per rising edge of next, regardless of hold time.
- State encoding: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, SHOW=4. Unused codes go to IDLE on the next clk.
- Transitions:
  - IDLE --step--> LOAD_A.
  - LOAD_A --step--> LOAD_B. A<=Din on the same edge.
  - LOAD_B --step--> EXEC. B<=Din and op<=MS on the same edge.
  - EXEC --unconditional, 1 cycle--> SHOW. Alu_out and flags are registered on the EXEC->SHOW edge.
  - SHOW --step--> LOAD_A. Alu_out and flags hold until the next EXEC.
  - A step in EXEC is ignored. It is not queued.
- Done_out is registered: high on the first cycle in SHOW, low on the cycle LOAD_A is entered.
- Latency: Alu_out is valid 2 clk after the LOAD_B step edge.
- ALU operations, all modulo 2^WIDTH:
  - 000 A+B: carry = bit WIDTH of the sum.
  - 001 A-B: carry = borrow (A<B unsigned).
  - 010 A&B.
  - 011 A|B.
  - 100 A^B.
  - 101 A<<1: carry = A[WIDTH-1].
  - 110 A>>1 logical: carry = A[0].
  - 111 pass A.
  - Overflow is the signed overflow for 000/001 and 0 for all other ops. Carry is 0 for the logic ops.
  - negative = result[WIDTH-1]; zero = (result==0).
- Display value:
  - LOAD_A/LOAD_B: live Din.
  - EXEC/SHOW: level ? A : Alu_out.
  - IDLE: 0.
- Scan: the counter runs 0..SCAN_DIV-1. On wrap, the digit index advances mod DIGITS (DIGITS-1 wraps to 0). LEDsel = ~(1<<index). digit = display value nibble [4*index+3:4*index], combinational from the registered index and value.
- Simultaneous events:
  - The reset assertion overrides everything.
  - A step on the same edge as a scan wrap: both take effect.
  - A Din change in the same cycle as a step: the value sampled at that edge is captured.
- Reset mid-operation, in any state: return to IDLE with all registers cleared as listed above. No partial result is retained.

Test Plan:
- Reset with next held high, then release clear → state_out=0, LEDsel=4'b1110, no step until next falls and rises again.
- Add with carry (WIDTH=16): steps A=16'hFFFF, B=16'h0002, MS=000 → Alu_out=16'h0001, flags=4'b1000, Done_out=1 two clk after the LOAD_B step.
- Sub with overflow: A=16'h8000, B=16'h0001, MS=001 → Alu_out=16'h7FFF, carry=0, overflow=1, negative=0, zero=0.
- Logic ops, one case each:
  - XOR: A=B=16'h5A5A, MS=100 → Alu_out=0, zero=1.
  - Shift left: MS=101 with A=16'h8001 → Alu_out=16'h0002, carry=1.
- Scan (SCAN_DIV=4, DIGITS=4): SHOW with Alu_out=16'h1234, level=0 → digit sequence 4,3,2,1,4 at 4-clk intervals, with LEDsel 1110,1101,1011,0111,1110. Then level=1 → digit shows the nibbles of A.
- Mid-operation reset and the SHOW→LOAD_A path:
  - clear pulsed low in LOAD_B → state 0, A=B=0, Alu_out=0.
  - Separately, a step in SHOW → state 1, Done_out=0, Alu_out unchanged.
